// File: rtl/product_accumulator.sv
`default_nettype none
// product_accumulator: sums a programmed number of multiplier products into a
// saturating accumulator and presents the total on a held valid/ready output. Rev 1.0
module product_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_terms,
  input  logic [2*N-1:0]     prod,
  input  logic               prod_valid,
  output logic               prod_ready,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic               overflow,
  output logic               busy
);

  generate
    if (ACC_W < 2*N) begin : g_width_check
      $error("product_accumulator: ACC_W must be >= 2*N");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] remaining;
  logic [ACC_W:0]   sum;
  logic             transfer;

  // One extra bit of headroom so the carry-out flags saturation.
  assign sum      = {1'b0, acc} + {{(ACC_W+1-2*N){1'b0}}, prod};
  assign transfer = prod_valid && (state == ACCUM);

  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == HOLD);
  assign busy       = (state != IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (num_terms == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (transfer && (remaining == CNT_W'(1))) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && start) begin
        acc       <= '0;
        overflow  <= 1'b0;
        remaining <= num_terms;
      end else if (transfer) begin
        remaining <= remaining - CNT_W'(1);
        if (sum[ACC_W]) begin
          acc      <= {ACC_W{1'b1}};
          overflow <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// tb_product_accumulator: directed vectors with hand-computed expectations. Rev 1.0
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_terms = '0;
  logic [15:0] prod = '0;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [23:0] acc;
  logic        acc_valid;
  logic        acc_ready = 1'b0;
  logic        overflow;
  logic        busy;

  // Narrow-accumulator instance used for the saturation case.
  logic        rst16 = 1'b1;
  logic        start16 = 1'b0;
  logic [7:0]  num_terms16 = '0;
  logic [15:0] prod16 = '0;
  logic        prod_valid16 = 1'b0;
  logic        prod_ready16;
  logic [15:0] acc16;
  logic        acc_valid16;
  logic        acc_ready16 = 1'b0;
  logic        overflow16;
  logic        busy16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  product_accumulator #(.N(8), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc(acc), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .overflow(overflow), .busy(busy)
  );

  product_accumulator #(.N(8), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .num_terms(num_terms16),
    .prod(prod16), .prod_valid(prod_valid16), .prod_ready(prod_ready16),
    .acc(acc16), .acc_valid(acc_valid16), .acc_ready(acc_ready16),
    .overflow(overflow16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] n);
    start = 1'b1;
    num_terms = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] p);
    prod = p;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic drain;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    rst16 = 1'b0;
    check("rst_acc", 32'(acc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(acc_valid), 0);
    check("rst_ready", 32'(prod_ready), 0);
    check("rst_ovf", 32'(overflow), 0);

    // 1: three back-to-back terms
    kick(8'd3);
    check("t1_ready", 32'(prod_ready), 1);
    check("t1_busy", 32'(busy), 1);
    send(16'd2);
    send(16'd3);
    check("t1_not_yet", 32'(acc_valid), 0);
    send(16'd4);
    check("t1_valid", 32'(acc_valid), 1);
    check("t1_acc", 32'(acc), 9);
    check("t1_ovf", 32'(overflow), 0);
    check("t1_ready_hold", 32'(prod_ready), 0);
    drain();
    check("t1_idle", 32'(busy), 0);

    // 2: bubbles between transfers
    kick(8'd4);
    send(16'd10);
    check("t2_acc1", 32'(acc), 10);
    prod = 16'd99;
    tick();
    check("t2_bubble1", 32'(acc), 10);
    send(16'd20);
    prod = 16'd77;
    tick();
    check("t2_bubble2", 32'(acc), 30);
    send(16'd30);
    check("t2_still_accum", 32'(acc_valid), 0);
    send(16'd40);
    check("t2_valid", 32'(acc_valid), 1);
    check("t2_acc", 32'(acc), 100);
    prod = 16'd5;
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    check("t2_hold_ignores_prod", 32'(acc), 100);
    drain();

    // 3: saturation on a 16-bit accumulator
    start16 = 1'b1;
    num_terms16 = 8'd3;
    tick();
    start16 = 1'b0;
    prod16 = 16'd65025;
    prod_valid16 = 1'b1;
    tick();
    check("t3_acc1", 32'(acc16), 65025);
    check("t3_ovf1", 32'(overflow16), 0);
    tick();
    tick();
    prod_valid16 = 1'b0;
    check("t3_valid", 32'(acc_valid16), 1);
    check("t3_acc", 32'(acc16), 32'hFFFF);
    check("t3_ovf", 32'(overflow16), 1);
    acc_ready16 = 1'b1;
    tick();
    acc_ready16 = 1'b0;
    check("t3_ovf_sticky", 32'(overflow16), 1);
    start16 = 1'b1;
    num_terms16 = 8'd2;
    tick();
    start16 = 1'b0;
    check("t3_restart_acc", 32'(acc16), 0);
    check("t3_restart_ovf", 32'(overflow16), 0);

    // 4: zero terms, consumer stalls
    kick(8'd0);
    check("t4_valid", 32'(acc_valid), 1);
    check("t4_acc", 32'(acc), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", 32'(acc_valid), 1);
      check("t4_hold_acc", 32'(acc), 0);
    end
    drain();
    check("t4_idle", 32'(busy), 0);

    // 5: reset mid-run
    kick(8'd5);
    send(16'd11);
    send(16'd12);
    check("t5_partial", 32'(acc), 23);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_acc", 32'(acc), 0);
    check("t5_ready", 32'(prod_ready), 0);
    prod = 16'd9;
    prod_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_valid", 32'(acc_valid), 0);
      check("t5_no_transfer", 32'(acc), 0);
    end
    prod_valid = 1'b0;
    kick(8'd1);
    send(16'd7);
    check("t5_valid", 32'(acc_valid), 1);
    check("t5_acc", 32'(acc), 7);
    drain();

    // 6: start ignored in ACCUM, HOLD and the HOLD->IDLE cycle
    kick(8'd2);
    start = 1'b1;
    num_terms = 8'd9;
    send(16'd5);
    check("t6_acc1", 32'(acc), 5);
    send(16'd6);
    check("t6_valid", 32'(acc_valid), 1);
    check("t6_acc", 32'(acc), 11);
    tick();
    check("t6_hold_acc", 32'(acc), 11);
    num_terms = 8'd1;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("t6_exit_idle", 32'(busy), 0);
    check("t6_exit_acc", 32'(acc), 11);
    tick();
    start = 1'b0;
    check("t6_accepted", 32'(prod_ready), 1);
    check("t6_cleared", 32'(acc), 0);
    send(16'd3);
    check("t6_new_valid", 32'(acc_valid), 1);
    check("t6_new_acc", 32'(acc), 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
